// File: rtl/rr_mux4_arbiter_pkg.sv
// Shared types and helpers for the four-way round-robin mux arbiter.
// Holds the FSM encoding, requester index constants and the one-hot helper.
package rr_mux4_arbiter_pkg;

  typedef enum logic {
    StIdle  = 1'b0,
    StGrant = 1'b1
  } state_e;

  localparam logic [1:0] IdxA = 2'd0;
  localparam logic [1:0] IdxB = 2'd1;
  localparam logic [1:0] IdxC = 2'd2;
  localparam logic [1:0] IdxD = 2'd3;

  function automatic logic [3:0] onehot4(logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/rr_mux4_arbiter_if.sv
// Requester/consumer bundle for rr_mux4_arbiter: four request lines with data,
// and the registered grant, select, data and valid returned by the arbiter.
interface rr_mux4_arbiter_if #(
  parameter int unsigned N = 4
);

  logic [3:0]   REQ;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [N-1:0] C;
  logic [N-1:0] D;
  logic [3:0]   GNT;
  logic [1:0]   S;
  logic [N-1:0] Y;
  logic         VALID;

  // Requester side drives requests and data; arbiter side returns the grant path.
  modport master (
    output REQ, A, B, C, D,
    input  GNT, S, Y, VALID
  );

  modport slave (
    input  REQ, A, B, C, D,
    output GNT, S, Y, VALID
  );

endinterface

// File: rtl/nBit4x1Multiplexer.sv
// Plain n-bit 4:1 multiplexer; select value equals the requester index.
module nBit4x1Multiplexer
  import rr_mux4_arbiter_pkg::*;
#(
  parameter int unsigned n = 4
) (
  input  logic [n-1:0] a_i,
  input  logic [n-1:0] b_i,
  input  logic [n-1:0] c_i,
  input  logic [n-1:0] d_i,
  input  logic [1:0]   s_i,
  output logic [n-1:0] y_o
);

  always_comb begin
    y_o = a_i;
    unique case (s_i)
      IdxA:    y_o = a_i;
      IdxB:    y_o = b_i;
      IdxC:    y_o = c_i;
      IdxD:    y_o = d_i;
      default: y_o = a_i;
    endcase
  end

endmodule

// File: rtl/rr_pick4.sv
// Combinational rotating priority encoder: first set request bit scanning
// upward from the pointer, wrapping modulo four.
module rr_pick4 (
  input  logic [3:0] req_i,
  input  logic [1:0] ptr_i,
  output logic       valid_o,
  output logic [1:0] idx_o
);

  always_comb begin
    logic [1:0] cand;
    valid_o = 1'b0;
    idx_o   = ptr_i;
    cand    = ptr_i;
    // Scan farthest-first so the candidate closest to the pointer wins last.
    for (int k = 3; k >= 0; k--) begin
      cand = ptr_i + 2'(k);
      if (req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter sharing one N-bit 4:1 mux between requesters A-D, with a
// per-grant hold limit and registered grant, select, data and valid.
module rr_mux4_arbiter
  import rr_mux4_arbiter_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic           clk,
  input  logic           rst,
  rr_mux4_arbiter_if.slave bus
);

  localparam int unsigned    CntW   = $clog2(MAX_HOLD + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MAX_HOLD);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  state_e          state_q, state_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [1:0]      s_q, s_d;
  logic [3:0]      gnt_q, gnt_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [N-1:0]    y_q, y_d;
  logic            valid_q, valid_d;

  logic [3:0]   eligible;
  logic [3:0]   pick_req;
  logic [1:0]   pick_ptr;
  logic         pick_valid;
  logic [1:0]   pick_idx;
  logic [1:0]   ptr_next;
  logic         release_grant;
  logic [N-1:0] mux_y;

  assign ptr_next      = s_q + 2'd1;
  assign release_grant = !bus.REQ[s_q] || (cnt_q == CntMax);

  // The holder competes on release only when nobody else is asking.
  always_comb begin
    eligible = bus.REQ;
    if (bus.REQ != onehot4(s_q)) begin
      eligible = bus.REQ & ~onehot4(s_q);
    end
  end

  always_comb begin
    pick_req = bus.REQ;
    pick_ptr = ptr_q;
    if (state_q == StGrant) begin
      pick_req = eligible;
      pick_ptr = ptr_next;
    end
  end

  rr_pick4 u_pick (
    .req_i   (pick_req),
    .ptr_i   (pick_ptr),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  nBit4x1Multiplexer #(
    .n (N)
  ) u_mux (
    .a_i (bus.A),
    .b_i (bus.B),
    .c_i (bus.C),
    .d_i (bus.D),
    .s_i (s_q),
    .y_o (mux_y)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    s_d     = s_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          gnt_d   = onehot4(pick_idx);
          s_d     = pick_idx;
          cnt_d   = CntOne;
          state_d = StGrant;
        end
      end
      StGrant: begin
        if (!release_grant) begin
          cnt_d = cnt_q + CntOne;
        end else begin
          ptr_d = ptr_next;
          if (pick_valid) begin
            gnt_d = onehot4(pick_idx);
            s_d   = pick_idx;
            cnt_d = CntOne;
          end else begin
            // S keeps its last value while idle.
            gnt_d   = 4'b0000;
            cnt_d   = '0;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    y_d     = (|gnt_q) ? mux_y : y_q;
    valid_d = |gnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= 2'd0;
      s_q     <= 2'd0;
      gnt_q   <= 4'b0000;
      cnt_q   <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      s_q     <= s_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      valid_q <= valid_d;
    end
  end

  assign bus.GNT   = gnt_q;
  assign bus.S     = s_q;
  assign bus.Y     = y_q;
  assign bus.VALID = valid_q;

  gnt_onehot0_a: assert property (@(posedge clk) $onehot0(gnt_q));
  cnt_bound_a:   assert property (@(posedge clk) cnt_q <= CntMax);

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Self-checking bench for rr_mux4_arbiter: directed scenarios plus random
// traffic against a behavioural round-robin model.
module tb_rr_mux4_arbiter;

  localparam int unsigned N        = 4;
  localparam int unsigned MAX_HOLD = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rr_mux4_arbiter_if #(.N(N)) bus ();

  rr_mux4_arbiter #(
    .N        (N),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // Model: who holds the path (-1 = nobody), pointer, hold count, outputs.
  int           m_holder;
  int           m_ptr;
  int           m_cnt;
  logic [1:0]   m_s;
  logic [N-1:0] m_y;
  logic         m_valid;
  logic [N-1:0] din [4];

  function automatic logic [3:0] exp_gnt();
    return (m_holder < 0) ? 4'b0000 : 4'(1 << m_holder);
  endfunction

  function automatic int pick(logic [3:0] r, int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  function automatic string obs_str();
    return $sformatf("gnt=%b s=%0d y=%h valid=%b", bus.GNT, bus.S, bus.Y, bus.VALID);
  endfunction

  function automatic string exp_str();
    return $sformatf("gnt=%b s=%0d y=%h valid=%b", exp_gnt(), m_s, m_y, m_valid);
  endfunction

  task automatic model_edge();
    int p;
    logic [3:0] elig;
    if (rst) begin
      m_holder = -1; m_ptr = 0; m_cnt = 0; m_s = 2'd0; m_y = '0; m_valid = 1'b0;
    end else begin
      m_valid = (m_holder >= 0);
      if (m_holder >= 0) m_y = din[m_s];
      if (m_holder < 0) begin
        p = pick(bus.REQ, m_ptr);
        if (p >= 0) begin
          m_holder = p; m_s = 2'(p); m_cnt = 1;
        end
      end else if (bus.REQ[m_holder] && m_cnt < int'(MAX_HOLD)) begin
        m_cnt++;
      end else begin
        m_ptr = (m_holder + 1) % 4;
        elig  = bus.REQ;
        if (elig != 4'(1 << m_holder)) elig[m_holder] = 1'b0;
        p = pick(elig, m_ptr);
        m_holder = p;
        if (p >= 0) begin
          m_s = 2'(p); m_cnt = 1;
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic [3:0] req);
    @(negedge clk);
    rst = r;
    bus.REQ = req;
    bus.A = din[0]; bus.B = din[1]; bus.C = din[2]; bus.D = din[3];
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) step(1'b1, 4'b1111);
    total++;
    if ({bus.GNT, bus.S, bus.Y, bus.VALID} !== {4'b0000, 2'd0, 4'h0, 1'b0}) begin
      bad++; $display("FAIL reset_values got %s exp gnt=0000 s=0 y=0 valid=0", obs_str());
    end
  endtask

  task automatic test_idle();
    step(1'b1, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 4'b0000);
      total++;
      if ({bus.GNT, bus.Y, bus.VALID} !== {4'b0000, 4'h0, 1'b0}) begin
        bad++; $display("FAIL idle i=%0d got %s exp gnt=0000 y=0 valid=0", i, obs_str());
      end
    end
  endtask

  task automatic test_sole();
    din[0] = 4'hA; din[1] = 4'h5; din[2] = 4'h6; din[3] = 4'h7;
    step(1'b1, 4'b0000);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, (i < 3) ? 4'b0001 : 4'b0000);
      total++;
      if ({bus.GNT, bus.S, bus.Y, bus.VALID} !== {exp_gnt(), m_s, m_y, m_valid}) begin
        bad++; $display("FAIL sole_model i=%0d got %s exp %s", i, obs_str(), exp_str());
      end
      if (i == 0) begin
        total++;
        if ({bus.GNT, bus.S} !== {4'b0001, 2'd0}) begin
          bad++; $display("FAIL sole_first_grant got %s exp gnt=0001 s=0", obs_str());
        end
      end
      if (i == 1) begin
        total++;
        if ({bus.Y, bus.VALID} !== {4'hA, 1'b1}) begin
          bad++; $display("FAIL sole_first_data got %s exp y=a valid=1", obs_str());
        end
      end
      if (i == 3) begin
        total++;
        if ({bus.GNT, bus.VALID} !== {4'b0000, 1'b1}) begin
          bad++; $display("FAIL sole_release got %s exp gnt=0000 valid=1", obs_str());
        end
      end
      if (i == 4) begin
        total++;
        if ({bus.Y, bus.VALID} !== {4'hA, 1'b0}) begin
          bad++; $display("FAIL sole_valid_fall got %s exp y=a valid=0", obs_str());
        end
      end
    end
  endtask

  task automatic test_fairness();
    logic [3:0] g;
    din[0] = 4'h1; din[1] = 4'h2; din[2] = 4'h3; din[3] = 4'h4;
    step(1'b1, 4'b0000);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 4'b1111);
      g = 4'(1 << ((i / 4) % 4));
      total++;
      if (bus.GNT !== g) begin
        bad++; $display("FAIL fair_gnt i=%0d got %s exp gnt=%b", i, obs_str(), g);
      end
      if (i >= 1) begin
        total++;
        if ({bus.Y, bus.VALID} !== {4'(((i - 1) / 4) % 4 + 1), 1'b1}) begin
          bad++; $display("FAIL fair_y i=%0d got %s exp y=%0d valid=1", i, obs_str(),
                          ((i - 1) / 4) % 4 + 1);
        end
      end
    end
  endtask

  task automatic test_rotation();
    logic [3:0] g;
    for (int k = 0; k < 4; k++) din[k] = N'($urandom);
    step(1'b1, 4'b0000);
    step(1'b0, 4'b0010);
    total++;
    if (bus.GNT !== 4'b0010) begin
      bad++; $display("FAIL rot_grant_b got %s exp gnt=0010", obs_str());
    end
    for (int j = 0; j < 9; j++) begin
      step(1'b0, 4'b1101);
      total++;
      if ({bus.GNT, bus.S, bus.Y, bus.VALID} !== {exp_gnt(), m_s, m_y, m_valid}) begin
        bad++; $display("FAIL rot_model j=%0d got %s exp %s", j, obs_str(), exp_str());
      end
      if (j == 0 || j == 4 || j == 8) begin
        g = (j == 0) ? 4'b0100 : (j == 4) ? 4'b1000 : 4'b0001;
        total++;
        if (bus.GNT !== g) begin
          bad++; $display("FAIL rot_order j=%0d got %s exp gnt=%b", j, obs_str(), g);
        end
      end
    end
  endtask

  task automatic test_sole_regrant();
    for (int k = 0; k < 4; k++) din[k] = N'($urandom);
    step(1'b1, 4'b0000);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 4'b0100);
      total++;
      if ({bus.GNT, bus.S} !== {4'b0100, 2'd2} || (i >= 1 && bus.VALID !== 1'b1)) begin
        bad++; $display("FAIL regrant i=%0d got %s exp gnt=0100 s=2 valid=%0d", i, obs_str(),
                        (i >= 1) ? 1 : 0);
      end
    end
  endtask

  task automatic test_reset_mid();
    din[0] = 4'h3; din[1] = 4'h0; din[2] = 4'h0; din[3] = 4'h9;
    step(1'b1, 4'b0000);
    step(1'b0, 4'b1000);
    step(1'b0, 4'b1000);
    total++;
    if ({bus.GNT, bus.S, bus.Y, bus.VALID} !== {4'b1000, 2'd3, 4'h9, 1'b1}) begin
      bad++; $display("FAIL rstmid_pre got %s exp gnt=1000 s=3 y=9 valid=1", obs_str());
    end
    step(1'b1, 4'b1000);
    total++;
    if ({bus.GNT, bus.S, bus.Y, bus.VALID} !== {4'b0000, 2'd0, 4'h0, 1'b0}) begin
      bad++; $display("FAIL rstmid_clear got %s exp gnt=0000 s=0 y=0 valid=0", obs_str());
    end
    step(1'b0, 4'b1001);
    total++;
    if ({bus.GNT, bus.S} !== {4'b0001, 2'd0}) begin
      bad++; $display("FAIL rstmid_ptr got %s exp gnt=0001 s=0", obs_str());
    end
  endtask

  task automatic test_random();
    logic [3:0] req;
    logic       r;
    req = 4'b0000;
    step(1'b1, 4'b0000);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 0) req = 4'($urandom_range(0, 15));
      r = ($urandom_range(0, 63) == 0);
      for (int k = 0; k < 4; k++) din[k] = N'($urandom);
      step(r, req);
      total++;
      if ({bus.GNT, bus.S, bus.Y, bus.VALID} !== {exp_gnt(), m_s, m_y, m_valid}) begin
        bad++; $display("FAIL random i=%0d got %s exp %s", i, obs_str(), exp_str());
      end
      total++;
      if (!$onehot0(bus.GNT)) begin
        bad++; $display("FAIL random_onehot i=%0d got gnt=%b exp at most one bit", i, bus.GNT);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bus.REQ = 4'b0000;
    for (int k = 0; k < 4; k++) din[k] = '0;
    bus.A = '0; bus.B = '0; bus.C = '0; bus.D = '0;
    m_holder = -1; m_ptr = 0; m_cnt = 0; m_s = 2'd0; m_y = '0; m_valid = 1'b0;
    test_reset();
    test_idle();
    test_sole();
    test_fairness();
    test_rotation();
    test_sole_regrant();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
